// File: rtl/pixel_stream_writer.sv
// Renderer pixel sink: raster-tags each incoming pixel and buffers it in a show-ahead FIFO
// feeding a ready/valid stream. The renderer cannot be stalled, so a full FIFO drops and counts pixels.
module pixel_stream_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          pixel_clk,
  input  logic                          pixel_rst_n,
  input  logic                          pixel_valid,
  input  logic [DATA_W-1:0]             pixel_data,
  input  logic                          frame_sync,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_RES - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [XW-1:0]     x_q, x_eff, x_nxt;
  logic [YW-1:0]     y_q, y_eff, y_nxt;
  logic              tag_sof, tag_eol, line_wrap, frame_wrap;
  logic              full, empty, wr_en, rd_en, drop;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [DATA_W+1:0] head;

  // frame_sync in the same cycle as a valid pixel makes that pixel itself (0,0)
  always_comb begin
    x_eff      = frame_sync ? '0 : x_q;
    y_eff      = frame_sync ? '0 : y_q;
    tag_sof    = (x_eff == '0) && (y_eff == '0);
    tag_eol    = (x_eff == X_LAST);
    line_wrap  = (x_eff == X_LAST);
    frame_wrap = line_wrap && (y_eff == Y_LAST);
    x_nxt      = line_wrap ? '0 : x_eff + XW'(1);
    y_nxt      = y_eff;
    if (line_wrap) begin
      y_nxt = frame_wrap ? '0 : y_eff + YW'(1);
    end
  end

  always_comb begin
    full  = (level == FULL_LVL);
    empty = (level == '0);
    wr_en = pixel_valid && !full;
    drop  = pixel_valid && full;
    rd_en = !empty && m_ready;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_count <= '0;
    end else if (pixel_valid) begin
      x_q <= x_nxt;
      y_q <= y_nxt;
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
    end else if (frame_sync) begin
      x_q <= '0;
      y_q <= '0;
    end
  end

  // Storage is cleared on reset so the stream outputs read zero until the first write
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= {tag_sof, tag_eol, pixel_data};
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as overflow_clr keeps the flag set
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign m_data     = head[DATA_W-1:0];
  assign m_eol      = head[DATA_W];
  assign m_sof      = head[DATA_W+1];
  assign m_valid    = !empty;
  assign fifo_level = level;

endmodule
